// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and FSM encoding for the RAM access front-end.
// The width constants are also used by the RAM top level.
package mem_access_ctrl_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 16;

  // 2'b11 is unused. The next-state logic sends it back to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

endpackage

// File: rtl/mem_rsp_reg.sv
// Read-response holding register with load, hold and clear.
// Clear is synchronous and takes priority over load.
module mem_rsp_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding request/response front-end for the 16K x 16 RAM.
// This block sequences the RAM strobes so that each access occupies exactly one ACCESS cycle.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              BUSY,
  output logic              RAM_E,
  output logic              RAM_W,
  output logic              RAM_R,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_D,
  input  logic [DATA_W-1:0] RAM_OUT,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // A valid signal is never withdrawn by this block. Ready depends only on registered state.
  state_e            state, state_nxt;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rdata;
  logic              in_access;
  logic              rd_load;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (state == IDLE && REQ_VALID) begin
      req_we    <= REQ_WE;
      req_addr  <= REQ_ADDR;
      req_wdata <= REQ_WDATA;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (REQ_VALID) state_nxt = ACCESS;
      ACCESS:  state_nxt = req_we ? IDLE : RESP;
      RESP:    if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM_OUT is X outside a read strobe, so it is captured only in a read ACCESS.
  assign rd_load = (state == ACCESS) && !req_we;

  mem_rsp_reg #(.W(DATA_W)) u_rsp_reg (
    .clk   (CLK),
    .clear (RST),
    .load  (rd_load),
    .d     (RAM_OUT),
    .q     (rdata)
  );

  // All outputs are decoded from registered state. RST forces them to their idle values.
  always_comb begin
    in_access = (state == ACCESS) && !RST;
    REQ_READY = (state == IDLE) && !RST;
    RSP_VALID = (state == RESP) && !RST;
    BUSY      = (state != IDLE) && !RST;
    RAM_E     = in_access;
    RAM_W     = in_access && req_we;
    RAM_R     = in_access && !req_we;
    RAM_ADDR  = RST ? '0 : req_addr;
    RAM_D     = RST ? '0 : req_wdata;
    RSP_RDATA = RST ? '0 : rdata;
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl, driving a behavioural 16K x 16 RAM
// whose read data is X whenever RAM_R is low.
module tb_mem_access_ctrl;

  logic        CLK;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [13:0] REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [15:0] RSP_RDATA;
  logic        BUSY;
  logic        RAM_E;
  logic        RAM_W;
  logic        RAM_R;
  logic [13:0] RAM_ADDR;
  logic [15:0] RAM_D;
  logic [15:0] RAM_OUT;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:16383];

  mem_access_ctrl dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .BUSY(BUSY), .RAM_E(RAM_E), .RAM_W(RAM_W), .RAM_R(RAM_R),
    .RAM_ADDR(RAM_ADDR), .RAM_D(RAM_D), .RAM_OUT(RAM_OUT),
    .dbg_state(dbg_state)
  );

  // clock / RAM model
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign RAM_OUT = RAM_R ? mem[RAM_ADDR] : 16'hxxxx;
  always @(posedge CLK) if (RAM_E && RAM_W) mem[RAM_ADDR] <= RAM_D;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // driver tasks: both start and end in IDLE, sampled 1 ns after an edge
  task automatic do_write(input logic [13:0] a, input logic [15:0] d);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = a; REQ_WDATA = d;
    tick();
    REQ_VALID = 1'b0;
    checks++;
    if (RAM_W !== 1'b1 || RAM_E !== 1'b1 || RAM_R !== 1'b0 || RAM_ADDR !== a || RAM_D !== d) begin
      failures++;
      $display("FAIL wr_strobe: W=%b E=%b R=%b addr=%h d=%h expected W=1 E=1 R=0 addr=%h d=%h",
               RAM_W, RAM_E, RAM_R, RAM_ADDR, RAM_D, a, d);
    end
    tick();
    checks++;
    if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0 || RAM_W !== 1'b0) begin
      failures++;
      $display("FAIL wr_done: req_ready=%b rsp_valid=%b ram_w=%b expected 1 0 0", REQ_READY, RSP_VALID, RAM_W);
    end
  endtask

  task automatic do_read(input logic [13:0] a, input logic [15:0] exp);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = a; REQ_WDATA = 16'hDEAD; RSP_READY = 1'b1;
    tick();
    REQ_VALID = 1'b0;
    checks++;
    if (RAM_R !== 1'b1 || RAM_W !== 1'b0 || RAM_ADDR !== a || RSP_VALID !== 1'b0) begin
      failures++;
      $display("FAIL rd_access: R=%b W=%b addr=%h rsp_valid=%b expected R=1 W=0 addr=%h rsp_valid=0",
               RAM_R, RAM_W, RAM_ADDR, RSP_VALID, a);
    end
    tick();
    checks++;
    if (RSP_VALID !== 1'b1 || RSP_RDATA !== exp) begin
      failures++;
      $display("FAIL rd_data@%h: valid=%b data=%h expected valid=1 data=%h", a, RSP_VALID, RSP_RDATA, exp);
    end
    tick();
    checks++;
    if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
      failures++;
      $display("FAIL rd_done: req_ready=%b rsp_valid=%b expected 1 0", REQ_READY, RSP_VALID);
    end
  endtask

  task automatic check_reset_outputs(input string name, input logic exp_ready);
    checks++;
    if (REQ_READY !== exp_ready || RSP_VALID !== 1'b0 || RSP_RDATA !== 16'h0 || BUSY !== 1'b0 ||
        RAM_E !== 1'b0 || RAM_W !== 1'b0 || RAM_R !== 1'b0 || RAM_ADDR !== 14'h0 || RAM_D !== 16'h0) begin
      failures++;
      $display("FAIL %s: rdy=%b vld=%b rdata=%h busy=%b E=%b W=%b R=%b addr=%h d=%h expected rdy=%b rest 0",
               name, REQ_READY, RSP_VALID, RSP_RDATA, BUSY, RAM_E, RAM_W, RAM_R, RAM_ADDR, RAM_D, exp_ready);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0; RSP_READY = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset_hold", 1'b0);
    RST = 1'b0;
    tick();
    check_reset_outputs("reset_release", 1'b1);
  endtask

  task automatic test_write_read();
    do_write(14'h0000, 16'h1234);
    do_write(14'h3FFF, 16'hBEEF);
    do_write(14'h1000, 16'h00FF);
    do_read(14'h0000, 16'h1234);
    do_read(14'h3FFF, 16'hBEEF);
    do_read(14'h1000, 16'h00FF);
  endtask

  task automatic test_strobe_hygiene();
    int r_cnt = 0;
    int e_cnt = 0;
    int bad   = 0;
    do_write(14'h0ABC, 16'h5A5A);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 14'h0ABC; RSP_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      REQ_VALID = 1'b0;
      if (RAM_R === 1'b1) r_cnt++;
      if (RAM_E === 1'b1) e_cnt++;
      if (RAM_W !== 1'b0 || $isunknown(RSP_RDATA)) bad++;
      if (i == 1) begin
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_RDATA !== 16'h5A5A) begin
          failures++;
          $display("FAIL hyg_data: valid=%b data=%h expected 1 5a5a", RSP_VALID, RSP_RDATA);
        end
      end
    end
    checks++;
    if (r_cnt != 1 || e_cnt != 1 || bad != 0) begin
      failures++;
      $display("FAIL hyg_strobes: r_cycles=%0d e_cycles=%0d bad=%0d expected 1 1 0", r_cnt, e_cnt, bad);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    do_write(14'h0200, 16'hC3C3);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 14'h0200; RSP_READY = 1'b0;
    tick();
    // a write offered during the stall must be ignored
    REQ_WE = 1'b1; REQ_WDATA = 16'hFFFF;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (RSP_VALID !== 1'b1 || RSP_RDATA !== 16'hC3C3 || REQ_READY !== 1'b0 || BUSY !== 1'b1 || RAM_E !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || RSP_VALID !== 1'b1 || RSP_RDATA !== 16'hC3C3) begin
      failures++;
      $display("FAIL bp_stall: bad_cycles=%0d valid=%b data=%h expected 0 1 c3c3", bad, RSP_VALID, RSP_RDATA);
    end
    REQ_VALID = 1'b0; RSP_READY = 1'b1;
    tick();
    checks++;
    if (RSP_VALID !== 1'b0 || REQ_READY !== 1'b1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: valid=%b ready=%b busy=%b expected 0 1 0", RSP_VALID, REQ_READY, BUSY);
    end
    do_read(14'h0200, 16'hC3C3);
  endtask

  task automatic test_back_to_back();
    logic [13:0] addrs [4];
    int bad = 0;
    addrs[0] = 14'd0; addrs[1] = 14'd1000; addrs[2] = 14'd2000; addrs[3] = 14'd3000;
    REQ_VALID = 1'b1; REQ_WE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      REQ_ADDR = addrs[i]; REQ_WDATA = 16'(i);
      if (REQ_READY !== 1'b1) bad++;
      tick();
      if (REQ_READY !== 1'b0 || RAM_W !== 1'b1 || RAM_ADDR !== addrs[i] || RAM_D !== 16'(i)) bad++;
      // scramble the request during ACCESS; it must not be latched
      REQ_ADDR = 14'h3333; REQ_WDATA = 16'hEEEE;
      if (i == 3) REQ_VALID = 1'b0;
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL b2b_cadence: bad=%0d expected 0", bad);
    end
    for (int i = 0; i < 4; i++) do_read(addrs[i], 16'(i));
  endtask

  task automatic test_reset_mid_write();
    do_write(14'h0010, 16'hAAAA);
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 14'h0010; REQ_WDATA = 16'h5555;
    tick();
    REQ_VALID = 1'b0;
    RST = 1'b1;
    #1;
    checks++;
    if (RAM_W !== 1'b0 || RAM_E !== 1'b0) begin
      failures++;
      $display("FAIL rstw_gate: W=%b E=%b expected 0 0", RAM_W, RAM_E);
    end
    tick();
    check_reset_outputs("rstw_after", 1'b0);
    RST = 1'b0;
    tick();
    check_reset_outputs("rstw_release", 1'b1);
    do_read(14'h0010, 16'hAAAA);
  endtask

  task automatic test_reset_in_resp();
    do_write(14'h0020, 16'h7777);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 14'h0020; RSP_READY = 1'b0;
    tick();
    REQ_VALID = 1'b0;
    tick();
    checks++;
    if (RSP_VALID !== 1'b1 || RSP_RDATA !== 16'h7777) begin
      failures++;
      $display("FAIL rstr_pre: valid=%b data=%h expected 1 7777", RSP_VALID, RSP_RDATA);
    end
    RST = 1'b1;
    tick();
    check_reset_outputs("rstr_after", 1'b0);
    RST = 1'b0; RSP_READY = 1'b1;
    tick();
    check_reset_outputs("rstr_release", 1'b1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe_hygiene();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_write();
    test_reset_in_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
